// File: rtl/dm_rst_ctrl.sv
// Debug reset/halt sequencer: stretches DM reset requests to a minimum width,
// releases the system before the core and keeps a sticky have-reset flag.
module dm_rst_ctrl #(
  parameter int RST_HOLD = 16,
  parameter int SEQ_GAP  = 4
) (
  input  logic dm_clk,
  input  logic dm_rst,
  input  logic ndmreset,
  input  logic hartreset,
  input  logic halt_req,
  input  logic ackhavereset,
  output logic core_rst_n,
  output logic sys_rst_n,
  output logic dm_core_rst_n,
  output logic core_halt_req,
  output logic core_havereset,
  output logic reset_busy
);

  localparam logic [7:0] HOLD_MAX  = 8'(RST_HOLD);
  localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD - 1);
  localparam logic [7:0] GAP_LAST  = 8'(SEQ_GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic       r_sys_scope;
  logic       w_sys_scope_nxt;
  logic       r_core_rst_n;
  logic       w_core_rst_n_nxt;
  logic       r_sys_rst_n;
  logic       w_sys_rst_n_nxt;
  logic       r_halt;
  logic       r_havereset;
  logic       w_set_havereset;
  logic       r_busy;
  logic       w_req;

  assign w_req = ndmreset | hartreset;

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_sys_scope_nxt  = r_sys_scope;
    w_core_rst_n_nxt = r_core_rst_n;
    w_sys_rst_n_nxt  = r_sys_rst_n;
    w_set_havereset  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_state_nxt      = ST_ASSERT;
          w_cnt_nxt        = 8'd0;
          w_sys_scope_nxt  = ndmreset;
          w_core_rst_n_nxt = 1'b0;
          w_sys_rst_n_nxt  = ~ndmreset;
        end
      end
      ST_ASSERT: begin
        if (r_cnt < HOLD_MAX) w_cnt_nxt = r_cnt + 8'd1;
        // A system request arriving during a hart-only reset widens the scope
        // and restarts the hold window from that edge.
        if (ndmreset && !r_sys_scope) begin
          w_sys_scope_nxt = 1'b1;
          w_sys_rst_n_nxt = 1'b0;
          w_cnt_nxt       = 8'd0;
        end else if ((r_cnt >= HOLD_LAST) && !w_req) begin
          w_state_nxt     = ST_RELEASE;
          w_cnt_nxt       = 8'd0;
          w_sys_rst_n_nxt = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (r_cnt != 8'hFF) w_cnt_nxt = r_cnt + 8'd1;
        if (w_req) begin
          w_state_nxt     = ST_ASSERT;
          w_cnt_nxt       = 8'd0;
          w_sys_scope_nxt = ndmreset;
          w_sys_rst_n_nxt = ~ndmreset;
        end else if (r_cnt == GAP_LAST) begin
          w_state_nxt      = ST_IDLE;
          w_core_rst_n_nxt = 1'b1;
          w_set_havereset  = 1'b1;
        end
      end
      default: begin
        w_state_nxt      = ST_ASSERT;
        w_cnt_nxt        = 8'd0;
        w_sys_scope_nxt  = 1'b1;
        w_core_rst_n_nxt = 1'b0;
        w_sys_rst_n_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge dm_clk or posedge dm_rst) begin
    if (dm_rst) begin
      r_state      <= ST_ASSERT;
      r_cnt        <= 8'd0;
      r_sys_scope  <= 1'b1;
      r_core_rst_n <= 1'b0;
      r_sys_rst_n  <= 1'b0;
      r_halt       <= 1'b0;
      r_havereset  <= 1'b0;
      r_busy       <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_sys_scope  <= w_sys_scope_nxt;
      r_core_rst_n <= w_core_rst_n_nxt;
      r_sys_rst_n  <= w_sys_rst_n_nxt;
      r_halt       <= halt_req;
      // Setting wins over an acknowledge landing on the same edge.
      r_havereset  <= w_set_havereset | (r_havereset & ~ackhavereset);
      r_busy       <= (w_state_nxt != ST_IDLE);
    end
  end

  assign core_rst_n     = r_core_rst_n;
  assign dm_core_rst_n  = r_core_rst_n;
  assign sys_rst_n      = r_sys_rst_n;
  assign core_halt_req  = r_halt;
  assign core_havereset = r_havereset;
  assign reset_busy     = r_busy;

endmodule

// File: tb/tb_dm_rst_ctrl.sv
// Bench for dm_rst_ctrl: timestamp-based reference model checked every cycle,
// directed reset scenarios with literal durations, then randomized requests.
module tb_dm_rst_ctrl;

  localparam int RST_HOLD = 16;
  localparam int SEQ_GAP  = 4;

  logic dm_clk       = 1'b0;
  logic dm_rst       = 1'b1;
  logic ndmreset     = 1'b0;
  logic hartreset    = 1'b0;
  logic halt_req     = 1'b0;
  logic ackhavereset = 1'b0;
  logic core_rst_n;
  logic sys_rst_n;
  logic dm_core_rst_n;
  logic core_halt_req;
  logic core_havereset;
  logic reset_busy;

  dm_rst_ctrl #(.RST_HOLD(RST_HOLD), .SEQ_GAP(SEQ_GAP)) dut (
    .dm_clk        (dm_clk),
    .dm_rst        (dm_rst),
    .ndmreset      (ndmreset),
    .hartreset     (hartreset),
    .halt_req      (halt_req),
    .ackhavereset  (ackhavereset),
    .core_rst_n    (core_rst_n),
    .sys_rst_n     (sys_rst_n),
    .dm_core_rst_n (dm_core_rst_n),
    .core_halt_req (core_halt_req),
    .core_havereset(core_havereset),
    .reset_busy    (reset_busy)
  );

  // clock / reset
  initial forever #5 dm_clk = ~dm_clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  // Reference model: a reset episode is described by when its hold window
  // started and when the system side was released (timestamps in edges).
  bit m_active    = 1'b1;
  bit m_scope     = 1'b1;
  bit m_hr        = 1'b0;
  bit m_halt      = 1'b0;
  int m_n         = 0;
  int m_hold_from = 0;
  int m_rel_at    = -1;

  task automatic model_step();
    bit req;
    bit done;
    if (dm_rst) begin
      m_active = 1'b1; m_scope = 1'b1; m_hr = 1'b0; m_halt = 1'b0;
      m_n = 0; m_hold_from = 0; m_rel_at = -1;
    end else begin
      m_n++;
      req  = ndmreset | hartreset;
      done = 1'b0;
      if (!m_active) begin
        if (req) begin
          m_active = 1'b1; m_hold_from = m_n; m_scope = ndmreset; m_rel_at = -1;
        end
      end else if (m_rel_at < 0) begin
        if (ndmreset && !m_scope) begin
          m_scope = 1'b1; m_hold_from = m_n;
        end else if (!req && (m_n - m_hold_from >= RST_HOLD)) begin
          m_rel_at = m_n;
        end
      end else begin
        if (req) begin
          m_hold_from = m_n; m_scope = ndmreset; m_rel_at = -1;
        end else if (m_n - m_rel_at == SEQ_GAP) begin
          m_active = 1'b0; done = 1'b1;
        end
      end
      if (done) m_hr = 1'b1;
      else if (ackhavereset) m_hr = 1'b0;
      m_halt = halt_req;
    end
  endtask

  initial forever begin
    @(posedge dm_clk or posedge dm_rst);
    model_step();
  end

  // scoreboard compare, every cycle on the inactive edge
  initial forever begin
    @(negedge dm_clk);
    if (chk_en) begin
      chk("core_rst_n",     int'(core_rst_n),     int'(!m_active));
      chk("sys_rst_n",      int'(sys_rst_n),      int'(!(m_active && m_scope && m_rel_at < 0)));
      chk("dm_core_rst_n",  int'(dm_core_rst_n),  int'(!m_active));
      chk("core_halt_req",  int'(core_halt_req),  int'(m_halt));
      chk("core_havereset", int'(core_havereset), int'(m_hr));
      chk("reset_busy",     int'(reset_busy),     int'(m_active));
    end
  end

  // Drives requests by edge index i (input sampled at edge i) and measures
  // how many observed cycles each reset spent low until the core is released.
  task automatic run_seq(input int h0, input int h1, input int n0, input int nl,
                         input int ack_at, output int core_low, output int sys_low,
                         output int gap);
    int sys_rise;
    int core_rise;
    core_low = 0; sys_low = 0; sys_rise = -1; core_rise = -1; gap = -1;
    for (int i = 0; i < 400; i++) begin
      hartreset    = (i == h0) || (i == h1);
      ndmreset     = (i >= n0) && (i < n0 + nl);
      ackhavereset = (i == ack_at);
      @(negedge dm_clk);
      if (!core_rst_n) core_low++;
      if (!sys_rst_n) sys_low++;
      if (sys_low > 0 && sys_rst_n && sys_rise < 0) sys_rise = i;
      if (core_low > 0 && core_rst_n) begin
        core_rise = i;
        break;
      end
    end
    hartreset = 1'b0; ndmreset = 1'b0; ackhavereset = 1'b0;
    if (core_rise < 0) chk("seq_timeout", 0, 1);
    if (sys_rise >= 0 && core_rise >= 0) gap = core_rise - sys_rise;
  endtask

  initial begin
    int cl, sl, gp, cnt;
    int ndm_left, hart_left;

    repeat (2) @(negedge dm_clk);
    chk_en = 1'b1;
    chk("rst_core_rst_n", int'(core_rst_n), 0);
    chk("rst_sys_rst_n",  int'(sys_rst_n),  0);
    chk("rst_busy",       int'(reset_busy), 1);
    chk("rst_havereset",  int'(core_havereset), 0);

    // power-on release
    dm_rst = 1'b0;
    cnt = 0;
    do begin @(negedge dm_clk); cnt++; end while (!sys_rst_n && cnt < 100);
    chk("por_sys_rise", cnt, 16);
    do begin @(negedge dm_clk); cnt++; end while (!core_rst_n && cnt < 100);
    chk("por_core_rise", cnt, 20);
    chk("por_havereset", int'(core_havereset), 1);
    chk("por_busy", int'(reset_busy), 0);
    ackhavereset = 1'b1; @(negedge dm_clk); ackhavereset = 1'b0;

    // hart-only pulse
    run_seq(0, -1, -1, 0, -1, cl, sl, gp);
    chk("hart_core_low", cl, 20);
    chk("hart_sys_low", sl, 0);
    chk("hart_havereset", int'(core_havereset), 1);
    ackhavereset = 1'b1; @(negedge dm_clk); ackhavereset = 1'b0;
    chk("ack_clears", int'(core_havereset), 0);

    // long system reset
    run_seq(-1, -1, 0, 40, -1, cl, sl, gp);
    chk("long_sys_low", sl, 40);
    chk("long_core_low", cl, 44);
    chk("long_gap", gp, 4);

    // scope upgrade
    run_seq(0, -1, 5, 1, -1, cl, sl, gp);
    chk("upg_sys_low", sl, 16);
    chk("upg_core_low", cl, 25);
    chk("upg_gap", gp, 4);

    // request in RELEASE
    run_seq(0, 18, -1, 0, -1, cl, sl, gp);
    chk("rel_core_low", cl, 38);
    chk("rel_sys_low", sl, 0);

    // halt across reset, ack coinciding with the set edge
    ackhavereset = 1'b1; @(negedge dm_clk); ackhavereset = 1'b0;
    halt_req = 1'b1;
    @(negedge dm_clk);
    chk("halt_latency", int'(core_halt_req), 1);
    run_seq(-1, -1, 0, 40, 44, cl, sl, gp);
    chk("halt_core_low", cl, 44);
    chk("halt_at_release", int'(core_halt_req), 1);
    chk("ack_vs_set", int'(core_havereset), 1);
    halt_req = 1'b0;

    // randomized requests with occasional mid-sequence async reset
    ndm_left = 0; hart_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (ndm_left > 0) ndm_left--;
      else if ($urandom_range(0, 99) < 2) ndm_left = $urandom_range(1, 40);
      if (hart_left > 0) hart_left--;
      else if ($urandom_range(0, 99) < 3) hart_left = $urandom_range(1, 20);
      ndmreset  = (ndm_left > 0);
      hartreset = (hart_left > 0);
      if ($urandom_range(0, 9) == 0) halt_req = ~halt_req;
      ackhavereset = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #3 dm_rst = 1'b1;
      end
      @(negedge dm_clk);
      dm_rst = 1'b0;
    end
    ndmreset = 1'b0; hartreset = 1'b0; ackhavereset = 1'b0; halt_req = 1'b0;
    repeat (40) @(negedge dm_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
